// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [1:0]      FETCH_ALIGN_MASK = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      VALID = 3'd3,
      FAULT = 3'd4
   } ifu_state_e;

endpackage

// File: rtl/ifu_perf_counter.sv
// Free-running wrapping event counter with enable.
module ifu_perf_counter
   import ifu_pkg::*;
#(
   parameter int unsigned WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Natural modulo-2^WIDTH wrap, no saturation.
   always_comb begin
      cnt_d = cnt_q + WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, one-outstanding request channel, and the
// ifu_valid/inst/pc/dnpc handshake to the single-cycle execute stage.
module ifu_fetch
   import ifu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [31:0] req_addr,
   input  logic        resp_valid,
   input  logic [31:0] resp_data,
   input  logic        resp_err,
   output logic        ifu_valid,
   output logic [31:0] inst,
   output logic [31:0] pc,
   input  logic [31:0] dnpc,
   output logic        fault,
   output logic [31:0] fault_pc,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   ifu_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] fault_pc_q, fault_pc_d;
   logic            req_valid_q, req_valid_d;
   logic            ifu_valid_q, ifu_valid_d;
   logic            fault_q, fault_d;
   logic            fetch_en_c;
   logic            stall_en_c;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      fault_pc_d = fault_pc_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (req_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (resp_valid) begin
               if (resp_err) begin
                  state_d    = FAULT;
                  fault_pc_d = pc_q;
               end else begin
                  inst_d  = resp_data;
                  state_d = VALID;
               end
            end
         end
         VALID: begin
            // pc follows dnpc even when the target turns out misaligned.
            pc_d = dnpc;
            if ((dnpc[1:0] & FETCH_ALIGN_MASK) != 2'b00) begin
               state_d    = FAULT;
               fault_pc_d = dnpc;
            end else begin
               state_d = REQ;
            end
         end
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs are decoded from the next state so they register with it.
   always_comb begin
      req_valid_d = (state_d == REQ);
      ifu_valid_d = (state_d == VALID);
      fault_d     = (state_d == FAULT);
      fetch_en_c  = (state_q == VALID);
      stall_en_c  = (state_q == REQ) || (state_q == WAIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q        <= RESET_PC;
         inst_q      <= NOP_INST;
         fault_pc_q  <= '0;
         req_valid_q <= 1'b0;
         ifu_valid_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         inst_q      <= inst_d;
         fault_pc_q  <= fault_pc_d;
         req_valid_q <= req_valid_d;
         ifu_valid_q <= ifu_valid_d;
         fault_q     <= fault_d;
      end
   end

   ifu_perf_counter #(.WIDTH(XLEN)) u_fetch_cnt (
      .clk   (clk),
      .rst_n (rst),
      .en    (fetch_en_c),
      .cnt   (fetch_cnt)
   );

   ifu_perf_counter #(.WIDTH(XLEN)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst),
      .en    (stall_en_c),
      .cnt   (stall_cnt)
   );

   assign req_valid = req_valid_q;
   assign req_addr  = pc_q;
   assign ifu_valid = ifu_valid_q;
   assign inst      = inst_q;
   assign pc        = pc_q;
   assign fault     = fault_q;
   assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: normal fetch stream, backpressure, bus error,
// misaligned target, reset during WAIT and fetch counter wrap.
module tb_ifu_fetch;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        ifu_valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] dnpc;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   int n_checks = 0;
   int n_errs   = 0;

   ifu_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .ifu_valid  (ifu_valid),
      .inst       (inst),
      .pc         (pc),
      .dnpc       (dnpc),
      .fault      (fault),
      .fault_pc   (fault_pc),
      .fetch_cnt  (fetch_cnt),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expects to be entered in REQ; leaves after the VALID edge (or after WAIT on error).
   task automatic run_fetch(input int rdy_dly, input int rsp_dly, input logic [31:0] data,
                            input logic err, input logic [31:0] exp_pc, input logic [31:0] dn);
      check32("req_valid_in_req", 32'(req_valid), 32'd1);
      check32("req_addr_in_req", req_addr, exp_pc);
      check32("ifu_valid_in_req", 32'(ifu_valid), 32'd0);
      for (int i = 0; i < rdy_dly; i++) begin
         req_ready = 1'b0;
         step();
         check32("req_valid_stable", 32'(req_valid), 32'd1);
         check32("req_addr_stable", req_addr, exp_pc);
         check32("ifu_valid_backpressure", 32'(ifu_valid), 32'd0);
      end
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      check32("req_valid_in_wait", 32'(req_valid), 32'd0);
      check32("ifu_valid_in_wait", 32'(ifu_valid), 32'd0);
      for (int i = 0; i < rsp_dly; i++) begin
         step();
         check32("req_valid_still_wait", 32'(req_valid), 32'd0);
         check32("ifu_valid_still_wait", 32'(ifu_valid), 32'd0);
      end
      resp_valid = 1'b1;
      resp_data  = data;
      resp_err   = err;
      step();
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_data  = 32'h0;
      if (err) begin
         check32("fault_on_err", 32'(fault), 32'd1);
         check32("fault_pc_on_err", fault_pc, exp_pc);
         check32("req_valid_on_err", 32'(req_valid), 32'd0);
         check32("ifu_valid_on_err", 32'(ifu_valid), 32'd0);
      end else begin
         check32("ifu_valid_in_valid", 32'(ifu_valid), 32'd1);
         check32("inst_in_valid", inst, data);
         check32("pc_in_valid", pc, exp_pc);
         dnpc = dn;
         step();
         check32("ifu_valid_after_valid", 32'(ifu_valid), 32'd0);
         check32("pc_after_valid", pc, dn);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check32({tag, "_req_valid"}, 32'(req_valid), 32'd0);
      check32({tag, "_ifu_valid"}, 32'(ifu_valid), 32'd0);
      check32({tag, "_fault"}, 32'(fault), 32'd0);
      check32({tag, "_fault_pc"}, fault_pc, 32'h0);
      check32({tag, "_pc"}, pc, 32'h8000_0000);
      check32({tag, "_req_addr"}, req_addr, 32'h8000_0000);
      check32({tag, "_inst"}, inst, 32'h0000_0013);
      check32({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
      check32({tag, "_stall_cnt"}, stall_cnt, 32'h0);
   endtask

   task automatic async_reset_release();
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      rst = 1'b1;
      step();
   endtask

   initial begin
      rst        = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_data  = 32'h0;
      resp_err   = 1'b0;
      dnpc       = 32'h0;

      // Reset state, then first fetches at the minimum 3-cycle period.
      step();
      step();
      check_reset_outputs("reset");
      rst = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         run_fetch(0, 0, 32'h0010_0093, 1'b0, 32'h8000_0000 + 32'(4 * k),
                   32'h8000_0004 + 32'(4 * k));
      end
      check32("fetch_cnt_after_3", fetch_cnt, 32'd3);
      check32("stall_cnt_after_3", stall_cnt, 32'd6);

      // Four cycles of backpressure in REQ.
      run_fetch(4, 0, 32'h0020_0113, 1'b0, 32'h8000_000C, 32'h8000_0010);
      check32("stall_cnt_backpressure", stall_cnt, 32'd12);
      check32("fetch_cnt_backpressure", fetch_cnt, 32'd4);

      // Bus error: terminal fault, counters frozen.
      run_fetch(0, 0, 32'hDEAD_BEEF, 1'b1, 32'h8000_0010, 32'h0);
      for (int k = 0; k < 4; k++) begin
         req_ready  = 1'b1;
         resp_valid = 1'b1;
         step();
         check32("fault_sticky", 32'(fault), 32'd1);
         check32("no_req_in_fault", 32'(req_valid), 32'd0);
         check32("no_valid_in_fault", 32'(ifu_valid), 32'd0);
      end
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      check32("fault_pc_err_held", fault_pc, 32'h8000_0010);
      check32("fetch_cnt_frozen", fetch_cnt, 32'd4);
      check32("stall_cnt_frozen", stall_cnt, 32'd14);
      check32("inst_held", inst, 32'h0020_0113);

      // Misaligned execute target.
      async_reset_release();
      run_fetch(0, 0, 32'h0010_0093, 1'b0, 32'h8000_0000, 32'h8000_0102);
      check32("fault_misalign", 32'(fault), 32'd1);
      check32("fault_pc_misalign", fault_pc, 32'h8000_0102);
      for (int k = 0; k < 3; k++) begin
         req_ready = 1'b1;
         step();
         check32("no_req_after_misalign", 32'(req_valid), 32'd0);
      end
      req_ready = 1'b0;
      check32("pc_after_misalign", pc, 32'h8000_0102);
      check32("fetch_cnt_misalign", fetch_cnt, 32'd1);
      check32("stall_cnt_misalign", stall_cnt, 32'd2);

      // Reset while in WAIT; late response is dropped.
      async_reset_release();
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      check32("in_wait_before_rst", 32'(req_valid), 32'd0);
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("rst_in_wait");
      resp_valid = 1'b1;
      resp_data  = 32'hDEAD_BEEF;
      step();
      rst = 1'b1;
      step();
      check32("refetch_req_valid", 32'(req_valid), 32'd1);
      check32("refetch_req_addr", req_addr, 32'h8000_0000);
      step();
      check32("resp_ignored_in_req", 32'(req_valid), 32'd1);
      check32("resp_ignored_ifu_valid", 32'(ifu_valid), 32'd0);
      check32("resp_ignored_inst", inst, 32'h0000_0013);
      resp_valid = 1'b0;
      resp_data  = 32'h0;
      run_fetch(0, 1, 32'h0050_0113, 1'b0, 32'h8000_0000, 32'h8000_0004);
      check32("fetch_cnt_after_refetch", fetch_cnt, 32'd1);
      check32("stall_cnt_after_refetch", stall_cnt, 32'd4);

      // Fetch counter wrap.
      force dut.u_fetch_cnt.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_fetch_cnt.cnt_q;
      #1;
      check32("fetch_cnt_preload", fetch_cnt, 32'hFFFF_FFFF);
      run_fetch(0, 0, 32'h0000_0013, 1'b0, 32'h8000_0004, 32'h8000_0008);
      check32("fetch_cnt_wrap", fetch_cnt, 32'h0);
      check32("stall_cnt_no_wrap", stall_cnt, 32'd6);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit feeding the single-cycle decode/execute/writeback stage. Holds the architectural PC, issues one instruction read per instruction over a valid/ready request channel, and waits for the response. It then presents `inst`/`pc` with a one-cycle `ifu_valid` pulse and captures the `dnpc` the execute stage computes combinationally in that same cycle. It is the producer end of the `ifu_valid`/`inst`/`pc`/`dnpc` interface.

## Interface
- `RESET_PC`, 32'h8000_0000: PC loaded on reset.
- `NOP_INST`, 32'h0000_0013: value of `inst` when no fetched instruction is held (`addi x0,x0,0`).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  out  1  instruction read request.
- `req_ready`  in  1  memory accepts the request.
- `req_addr`  out  32  fetch address; equals `pc`.
- `resp_valid`  in  1  read data is returned.
- `resp_data`  in  32  instruction word.
- `resp_err`  in  1  bus error on the response.
- `ifu_valid`  out  1  `inst`/`pc` valid for exactly this cycle.
- `inst`  out  32  held instruction word.
- `pc`  out  32  architectural PC.
- `dnpc`  in  32  next PC from execute; sampled only when `ifu_valid`=1.
- `fault`  out  1  sticky fetch fault; the unit has halted.
- `fault_pc`  out  32  PC at which the fault occurred.
- `fetch_cnt`  out  32  count of `ifu_valid` cycles.
- `stall_cnt`  out  32  count of cycles spent in REQ or WAIT.

## Operation
- States: IDLE, REQ, WAIT, VALID, FAULT.
- IDLE: entered only by reset. Always goes to REQ on the next edge.
- REQ: `req_valid`=1 and `req_addr`=`pc`.
  - Goes to WAIT when `req_ready`=1.
  - `req_addr` holds stable while `req_valid`=1.
  - `resp_valid` in this state is ignored.
- WAIT: `req_valid`=0.
  - On `resp_valid`=1 with `resp_err`=0: `inst`<=`resp_data` and go to VALID.
  - On `resp_valid`=1 with `resp_err`=1: go to FAULT.
  - Otherwise stay in WAIT.
- VALID: `ifu_valid`=1 for one cycle. On the edge, `pc`<=`dnpc`.
  - If `dnpc[1:0]`!=0: go to FAULT with `fault_pc`<=`dnpc`. `pc` is still updated.
  - Otherwise go to REQ.
- FAULT: terminal until reset.
  - `fault`=1; `req_valid`=0; `ifu_valid`=0.
  - On a bus error, `fault_pc` is the faulting `pc`.
  - On misalignment, `fault_pc` is the misaligned target.
- `inst` keeps its last value outside VALID. It returns to `NOP_INST` only on reset.
- Counters:
  - `fetch_cnt` += 1 on each VALID cycle.
  - `stall_cnt` += 1 on each REQ or WAIT cycle.
  - Both wrap modulo 2^32 with no saturation.
  - Both freeze in FAULT.
- Reset values:
  - state=IDLE, `pc`=`RESET_PC`, `inst`=`NOP_INST`.
  - `ifu_valid`=0, `req_valid`=0, `fault`=0, `fault_pc`=0.
  - counters=0.
- Reset mid-operation: an in-flight request or response is abandoned.
  - The memory side must tolerate a dropped response.
  - After reset the unit refetches from `RESET_PC`.

## Timing
- `ifu_valid`, `req_valid`, `fault` and `req_addr` are pure functions of registered state (Moore). There is no combinational path from inputs to them.
- `dnpc` is combinational from `inst`/`pc` in the execute stage. It is sampled only at the VALID edge.
- Minimum instruction period is 3 cycles (REQ, WAIT, VALID). This requires `req_ready`=1 in REQ and `resp_valid`=1 in the first WAIT cycle.
- First `ifu_valid` comes no earlier than cycle 4 after reset deassertion (IDLE, REQ, WAIT, VALID).
- Exactly one outstanding request. `resp_valid` must arrive ≥1 cycle after request acceptance.
- Asserting `req_ready` while `req_valid`=0 has no effect.

## Structure
- Shared package `ifu_pkg` holds:
  - the state enum (IDLE/REQ/WAIT/VALID/FAULT, 3-bit encoding);
  - `RESET_PC` and `NOP_INST` defaults;
  - the `FETCH_ALIGN_MASK`=2'b11 constant.
- One sub-module, `ifu_perf_counter`: a 32-bit wrapping counter with enable and asynchronous active-low reset. It is instantiated twice.
- The FSM, PC register, instruction register and fault capture live in `ifu_fetch`.

## Test plan
- Reset-release with `req_ready`=1 and `resp_valid` one cycle after acceptance, `resp_data`=32'h00100093, execute returning `dnpc`=`pc`+4:
  - `ifu_valid` pulses every 3 cycles;
  - PCs are 80000000, 80000004, 80000008;
  - after 3 fetches `fetch_cnt`=3 and `stall_cnt`=6.
- `req_ready` held low 4 cycles in REQ:
  - `req_valid` and `req_addr` remain stable;
  - `stall_cnt` grows by 4 extra;
  - no `ifu_valid`.
- Response with `resp_err`=1 at pc 80000010:
  - `fault`=1 and `fault_pc`=80000010;
  - `req_valid`=0 and `ifu_valid`=0 thereafter;
  - counters frozen.
- Execute returns `dnpc`=80000102:
  - `fault`=1 and `fault_pc`=80000102;
  - no further request issued.
- Assert `rst` low during WAIT, then drop the late response:
  - all outputs return to reset values asynchronously;
  - the next request has `req_addr`=80000000.
- Preload `fetch_cnt` near wrap (force 32'hFFFFFFFF), then one more fetch: `fetch_cnt`=0.
